// File: rtl/serial_reg_loader.sv
// 8N1 UART receiver that decodes header/data byte pairs into APU register-write strobes
// and keeps a link-activity indicator alive for a fixed time after each good byte.
module serial_reg_loader #(
  parameter int OSCRATE  = 12_000_000,
  parameter int BAUDRATE = 9600,
  parameter int LINKTIME = OSCRATE / 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       reg_we,
  output logic [4:0] reg_addr,
  output logic [7:0] reg_data,
  output logic       link
);

  localparam int DIV  = OSCRATE / BAUDRATE;
  localparam int HALF = DIV / 2;
  localparam int CW   = ($clog2(DIV + 1) < 11) ? 11 : $clog2(DIV + 1);
  localparam int LW   = ($clog2(LINKTIME + 1) < 1) ? 1 : $clog2(LINKTIME + 1);

  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [LW-1:0] LINK_LOAD = LW'(LINKTIME);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         state_q, state_d;
  logic           sync1_q, sync1_d;
  logic           sync2_q, sync2_d;
  logic           rxs_prev_q, rxs_prev_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     idx_q, idx_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     rx_data_q, rx_data_d;
  logic           rx_valid_q, rx_valid_d;
  logic           frame_err_q, frame_err_d;
  logic           armed_q, armed_d;
  logic           reg_we_q, reg_we_d;
  logic [4:0]     reg_addr_q, reg_addr_d;
  logic [7:0]     reg_data_q, reg_data_d;
  logic [LW-1:0]  link_cnt_q, link_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      rxs_prev_q  <= 1'b1;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      armed_q     <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_data_q  <= '0;
      link_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      rxs_prev_q  <= rxs_prev_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      armed_q     <= armed_d;
      reg_we_q    <= reg_we_d;
      reg_addr_q  <= reg_addr_d;
      reg_data_q  <= reg_data_d;
      link_cnt_q  <= link_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sync1_d     = rx;
    sync2_d     = sync1_q;
    rxs_prev_d  = sync2_q;
    cnt_d       = cnt_q + CW'(1);
    idx_d       = idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    armed_d     = armed_q;
    reg_we_d    = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_data_d  = reg_data_q;
    link_cnt_d  = link_cnt_q;

    // Receiver: start detect needs a true 1->0 transition so a stuck-low line is ignored.
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rxs_prev_q && !sync2_q) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (sync2_q) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            idx_d   = '0;
          end
        end
      end
      DATA: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (sync2_q) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Framer: a header arms the next byte as data; a stray data byte resynchronizes.
    if (rx_valid_q) begin
      if (armed_q) begin
        reg_data_d = rx_data_q;
        reg_we_d   = 1'b1;
        armed_d    = 1'b0;
      end else if (rx_data_q[7]) begin
        reg_addr_d = rx_data_q[4:0];
        armed_d    = 1'b1;
      end
    end
    if (frame_err_q) armed_d = 1'b0;

    if (rx_valid_q) begin
      link_cnt_d = LINK_LOAD;
    end else if (link_cnt_q != '0) begin
      link_cnt_d = link_cnt_q - LW'(1);
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign reg_we    = reg_we_q;
  assign reg_addr  = reg_addr_q;
  assign reg_data  = reg_data_q;
  assign link      = (link_cnt_q != '0);

endmodule

// File: tb/tb_serial_reg_loader.sv
// Directed bench for serial_reg_loader: bytes are serialized onto rx and the expected
// received bytes, frame errors and register writes are queued and matched as they appear.
`timescale 1ns/1ps
module tb_serial_reg_loader;

  localparam int  OSC    = 160_000;
  localparam int  BAUD   = 10_000;
  localparam int  DIV    = OSC / BAUD;
  localparam int  HALF   = DIV / 2;
  localparam int  LT     = 300;
  localparam real BIT_NS = 160.0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       reg_we;
  logic [4:0] reg_addr;
  logic [7:0] reg_data;
  logic       link;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int valid_cyc = 0;
  int link_fall_cyc = 0;
  int rx_valid_cnt = 0;
  int reg_we_cnt = 0;
  int exp_fe = 0;
  logic link_prev = 1'b0;
  logic [7:0]  exp_rx[$];
  logic [12:0] exp_wr[$];
  bit          model_armed = 1'b0;
  logic [4:0]  model_addr = '0;

  serial_reg_loader #(.OSCRATE(OSC), .BAUDRATE(BAUD), .LINKTIME(LT)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_err(frame_err), .reg_we(reg_we), .reg_addr(reg_addr), .reg_data(reg_data),
    .link(link)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Serialize one 8N1 byte and record what the receiver and framer should produce.
  task automatic apply_stimulus(input logic [7:0] b, input logic stop_bit, input real bit_ns);
    if (stop_bit) begin
      exp_rx.push_back(b);
      if (model_armed) begin
        exp_wr.push_back({model_addr, b});
        model_armed = 1'b0;
      end else if (b[7]) begin
        model_addr  = b[4:0];
        model_armed = 1'b1;
      end
    end else begin
      exp_fe++;
      model_armed = 1'b0;
    end
    start_cyc = cyc;
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_ns);
    end
    rx = stop_bit;
    #(bit_ns);
    rx = 1'b1;
  endtask

  task automatic drain(input string tag);
    wait_cycles(3 * DIV);
    check_output({tag, "_rx_drained"}, exp_rx.size(), 0);
    check_output({tag, "_wr_drained"}, exp_wr.size(), 0);
    check_output({tag, "_fe_drained"}, exp_fe, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_rx_data"}, rx_data, 0);
    check_output({tag, "_rx_valid"}, rx_valid, 0);
    check_output({tag, "_frame_err"}, frame_err, 0);
    check_output({tag, "_reg_we"}, reg_we, 0);
    check_output({tag, "_reg_addr"}, reg_addr, 0);
    check_output({tag, "_reg_data"}, reg_data, 0);
    check_output({tag, "_link"}, link, 0);
  endtask

  // Output monitor: every pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        rx_valid_cnt++;
        valid_cyc = cyc;
        check_output("rx_valid_pending", exp_rx.size() > 0, 1);
        if (exp_rx.size() > 0) check_output("rx_data", rx_data, exp_rx.pop_front());
      end
      if (frame_err) begin
        check_output("frame_err_pending", exp_fe > 0, 1);
        if (exp_fe > 0) exp_fe--;
      end
      if (reg_we) begin
        reg_we_cnt++;
        check_output("reg_we_pending", exp_wr.size() > 0, 1);
        if (exp_wr.size() > 0) check_output("reg_write", {reg_addr, reg_data}, exp_wr.pop_front());
      end
    end
    if (link_prev && !link) link_fall_cyc = cyc;
    link_prev = link;
  end

  initial begin
    int lat;
    int hold;

    wait_cycles(3);
    check_reset_values("reset");
    rst_n = 1'b1;
    wait_cycles(4);

    // Single byte: latency, link assertion and link timeout.
    @(negedge clk);
    apply_stimulus(8'h55, 1'b1, BIT_NS);
    check_output("link_high", link, 1);
    drain("b55");
    lat = valid_cyc - start_cyc - 1;
    check_output("latency_window", (lat >= HALF + 9 * DIV + 2) && (lat <= HALF + 9 * DIV + 4), 1);
    wait_cycles(LT);
    check_output("link_low", link, 0);
    hold = link_fall_cyc - valid_cyc;
    check_output("link_hold_window", (hold >= LT - 2) && (hold <= LT + 2), 1);

    // Header/data pair, then a lone data byte.
    apply_stimulus(8'h83, 1'b1, BIT_NS);
    apply_stimulus(8'hA5, 1'b1, BIT_NS);
    drain("pair");
    check_output("pair_addr", reg_addr, 5'd3);
    check_output("pair_data", reg_data, 8'hA5);
    apply_stimulus(8'h05, 1'b1, BIT_NS);
    drain("lone");
    check_output("lone_we_count", reg_we_cnt, 1);

    // Start-bit glitch shorter than half a bit.
    rx = 1'b0;
    wait_cycles(4);
    rx = 1'b1;
    wait_cycles(2 * DIV);
    check_output("glitch_idle", 32'(dut.state_q), 0);
    check_output("glitch_valid_count", rx_valid_cnt, 4);
    apply_stimulus(8'h3C, 1'b1, BIT_NS);
    drain("b3c");

    // Framing error drops an armed header; stray data is discarded before the next pair.
    apply_stimulus(8'h9F, 1'b1, BIT_NS);
    apply_stimulus(8'h44, 1'b0, BIT_NS);
    wait_cycles(DIV);
    drain("ferr");
    check_output("ferr_rx_hold", rx_data, 8'h9F);
    check_output("ferr_we_count", reg_we_cnt, 1);
    apply_stimulus(8'h12, 1'b1, BIT_NS);
    apply_stimulus(8'h81, 1'b1, BIT_NS);
    apply_stimulus(8'h00, 1'b1, BIT_NS);
    drain("resync");
    check_output("resync_addr", reg_addr, 5'd1);
    check_output("resync_data", reg_data, 8'h00);

    // Reset in the middle of data bit 4 of 0xF0.
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      rx = 1'(8'hF0 >> i);
      #(BIT_NS);
    end
    rx = 1'b1;
    #(BIT_NS / 2.0);
    rst_n = 1'b0;
    model_armed = 1'b0;
    #(33);
    rst_n = 1'b1;
    wait_cycles(2 * DIV);
    check_reset_values("midreset");
    apply_stimulus(8'h0F, 1'b1, BIT_NS);
    drain("b0f");

    // Back-to-back header/data pairs with slow then fast bit clocks.
    apply_stimulus(8'hFF, 1'b1, BIT_NS * 1.02);
    apply_stimulus(8'h00, 1'b1, BIT_NS * 1.02);
    apply_stimulus(8'hFF, 1'b1, BIT_NS * 0.98);
    apply_stimulus(8'h00, 1'b1, BIT_NS * 0.98);
    drain("skew");
    check_output("skew_addr", reg_addr, 5'd31);
    check_output("skew_data", reg_data, 8'h00);
    check_output("skew_we_count", reg_we_cnt, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
